// File: rtl/id_exe_pipe_reg.sv
// id_exe_pipe_reg: ID/EXE pipeline register with valid/ready handshake, stall hold, flush-to-bubble
// and a saturating bubble counter; optional load-use bubble insertion under LOAD_USE_DETECT_EN.
module id_exe_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int WB_W       = 2,
    parameter int MEM_W      = 3,
    parameter int EXE_W      = 4,
    parameter int MEM_RD_BIT = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] sign_extended,
    input  logic [REG_W-1:0]  instruction1,
    input  logic [REG_W-1:0]  instruction2,
    input  logic [WB_W-1:0]   WB,
    input  logic [MEM_W-1:0]  MEM,
    input  logic [EXE_W-1:0]  EXE,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pcOut,
    output logic [DATA_W-1:0] readData1Out,
    output logic [DATA_W-1:0] readData2Out,
    output logic [DATA_W-1:0] sign_extendedOut,
    output logic [REG_W-1:0]  instruction1Out,
    output logic [REG_W-1:0]  instruction2Out,
    output logic [WB_W-1:0]   WBOut,
    output logic [MEM_W-1:0]  MEMOut,
    output logic [EXE_W-1:0]  EXEOut,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, se_q, se_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d;
    logic [WB_W-1:0]   wb_q, wb_d;
    logic [MEM_W-1:0]  mem_q, mem_d;
    logic [EXE_W-1:0]  exe_q, exe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              advance, capture, bubble;

    always_comb begin
        advance = !valid_q || out_ready;
`ifdef LOAD_USE_DETECT_EN
        hazard_stall = in_valid && valid_q && mem_q[MEM_RD_BIT] && rt_q != '0 &&
                       (instruction1 == rt_q || instruction2 == rt_q);
`else
        hazard_stall = 1'b0;
`endif
        in_ready = flush || (advance && !hazard_stall);
        capture  = in_valid && in_ready && !flush;
        // a bubble is a flush or a load-use drain; at most one count per edge
        bubble   = flush || (hazard_stall && advance);
        valid_d  = capture ? 1'b1 : (advance || flush) ? 1'b0 : valid_q;
        pc_d     = capture ? pc            : pc_q;
        rd1_d    = capture ? readData1     : rd1_q;
        rd2_d    = capture ? readData2     : rd2_q;
        se_d     = capture ? sign_extended : se_q;
        rs_d     = capture ? instruction1  : rs_q;
        rt_d     = capture ? instruction2  : rt_q;
        // control fields are zeroed whenever the entry stops being valid
        wb_d     = capture ? WB  : (advance || flush) ? '0 : wb_q;
        mem_d    = capture ? MEM : (advance || flush) ? '0 : mem_q;
        exe_d    = capture ? EXE : (advance || flush) ? '0 : exe_q;
        cnt_d    = (bubble && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            se_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wb_q    <= '0;
            mem_q   <= '0;
            exe_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            se_q    <= se_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            exe_q   <= exe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid        = valid_q;
    assign pcOut            = pc_q;
    assign readData1Out     = rd1_q;
    assign readData2Out     = rd2_q;
    assign sign_extendedOut = se_q;
    assign instruction1Out  = rs_q;
    assign instruction2Out  = rt_q;
    assign WBOut            = wb_q;
    assign MEMOut           = mem_q;
    assign EXEOut           = exe_q;
    assign bubble_count     = cnt_q;
endmodule
